// File: rtl/axi_reg_master_if.sv
// Single-beat capable AXI4 bundle shared by register masters and slaves.
interface axi_ifc #(
  parameter int ID_W = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  logic [ID_W-1:0] awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [ID_W-1:0] arid;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_reg_master.sv
// Single-outstanding AXI master: one register command in, one single-beat
// AXI transaction out, one response back. Commands are fully serialized.
module axi_reg_master #(
  parameter logic [3:0] TXN_ID      = 4'd0,
  parameter bit         ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  axi_ifc.master      m
);
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RSP} state_t;

  state_t      state, state_n;
  logic        aw_pend, aw_pend_n;
  logic        w_pend, w_pend_n;
  logic [31:2] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept, misaligned;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign accept     = cmd_valid & cmd_ready;
  assign misaligned = ALIGN_CHECK && (cmd_addr[1:0] != 2'b00);

  // All handshake-side outputs decode from registered state, so an async
  // reset drops them immediately and they can never glitch mid-cycle.
  assign cmd_ready = (state == IDLE) & ~reset;
  assign rsp_valid = (state == RSP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign m.awvalid = (state == WADDR) & aw_pend;
  assign m.wvalid  = (state == WADDR) & w_pend;
  assign m.bready  = (state == WRESP);
  assign m.arvalid = (state == RADDR);
  assign m.rready  = (state == RDATA);

  // Low address bits are never stored: misaligned commands never reach the
  // bus when checked, and are truncated to a word boundary otherwise.
  assign m.awaddr  = {addr_q, 2'b00};
  assign m.araddr  = {addr_q, 2'b00};
  assign m.wdata   = wdata_q;
  assign m.awid    = TXN_ID;
  assign m.arid    = TXN_ID;
  assign m.awlen   = 8'd0;
  assign m.arlen   = 8'd0;
  assign m.awsize  = 3'd2;
  assign m.arsize  = 3'd2;
  assign m.awburst = 2'b01;
  assign m.arburst = 2'b01;
  assign m.wstrb   = 4'hF;
  assign m.wlast   = 1'b1;

  assign aw_hs = m.awvalid & m.awready;
  assign w_hs  = m.wvalid  & m.wready;
  assign b_hs  = m.bvalid  & m.bready;
  assign ar_hs = m.arvalid & m.arready;
  assign r_hs  = m.rvalid  & m.rready;

  // State and per-channel pending flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else begin
      state   <= state_n;
      aw_pend <= aw_pend_n;
      w_pend  <= w_pend_n;
    end
  end

  // Next state; AW and W retire independently and in any order.
  always_comb begin
    state_n   = state;
    aw_pend_n = aw_pend;
    w_pend_n  = w_pend;
    unique case (state)
      IDLE: if (accept) begin
        if (misaligned) state_n = RSP;
        else if (cmd_write) begin
          state_n   = WADDR;
          aw_pend_n = 1'b1;
          w_pend_n  = 1'b1;
        end else state_n = RADDR;
      end
      WADDR: begin
        if (aw_hs) aw_pend_n = 1'b0;
        if (w_hs)  w_pend_n  = 1'b0;
        if (!aw_pend_n && !w_pend_n) state_n = WRESP;
      end
      WRESP:   if (b_hs) state_n = RSP;
      RADDR:   if (ar_hs) state_n = RDATA;
      RDATA:   if (r_hs) state_n = RSP;
      RSP:     if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Command capture and response latching; held stable through RSP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= cmd_addr[31:2];
        wdata_q <= cmd_wdata;
        rdata_q <= '0;
        err_q   <= misaligned;
      end
      if (b_hs) begin
        rdata_q <= '0;
        err_q   <= (m.bresp != 2'b00) | (m.bid != TXN_ID);
      end
      if (r_hs) begin
        rdata_q <= m.rdata;
        err_q   <= (m.rresp != 2'b00) | (m.rid != TXN_ID) | ~m.rlast;
      end
    end
  end
endmodule

// File: tb/tb_axi_reg_master.sv
// Bench for axi_reg_master: configurable AXI slave model plus a flat
// memory reference model for expected read data and error status.
module tb_axi_reg_master;
  localparam logic [3:0] TID = 4'h5;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  axi_ifc bus();

  axi_reg_master #(.TXN_ID(TID), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // slave configuration
  int aw_dly, w_dly, ar_dly, b_dly, r_dly;
  bit rdy_early;
  logic [1:0] bresp_cfg, rresp_cfg;
  logic [3:0] bid_cfg, rid_cfg;
  logic rlast_cfg;

  // slave bookkeeping
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  int aw_n, w_n, ar_n, b_n, r_n, any_valid;
  int aw_hs_cyc, w_hs_cyc, aw_hold, ar_hold;
  bit b_drop, r_drop, aw_unstable, ar_unstable;
  logic [31:0] prev_awaddr, prev_araddr;
  logic [31:0] aw_q[$], wd_q[$], ar_q[$];
  logic [31:0] last_awaddr, last_wdata;
  logic [7:0]  last_awlen;
  logic [2:0]  last_awsize;
  logic [1:0]  last_awburst;
  logic [3:0]  last_awid, last_arid;
  logic [3:0]  last_wstrb;
  logic        last_wlast;
  logic [31:0] smem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  bit hold_bad, ready_after;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic cfg_default();
    aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0; rdy_early = 0;
    bresp_cfg = 2'b00; rresp_cfg = 2'b00; bid_cfg = TID; rid_cfg = TID; rlast_cfg = 1'b1;
  endtask

  task automatic slv_clear();
    bus.awready = 0; bus.wready = 0; bus.arready = 0;
    bus.bvalid = 0; bus.bresp = 0; bus.bid = 0;
    bus.rvalid = 0; bus.rresp = 0; bus.rid = 0; bus.rdata = 0; bus.rlast = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0;
    b_drop = 0; r_drop = 0;
    aw_q.delete(); wd_q.delete(); ar_q.delete();
  endtask

  // Slave model: all decisions at the falling edge; a handshake is logged
  // when valid and ready are both high here, since neither moves before the
  // next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      logic [31:0] a;
      if (bus.awvalid | bus.wvalid | bus.arvalid) any_valid++;
      // B: only after AW and W have both completed on earlier edges
      if (b_drop) begin bus.bvalid = 0; b_drop = 0; end
      else if (!bus.bvalid && aw_n > b_n && w_n > b_n) begin
        if (b_cnt >= b_dly) begin bus.bvalid = 1; bus.bresp = bresp_cfg; bus.bid = bid_cfg; end
        else b_cnt++;
      end
      if (bus.bvalid && bus.bready) begin
        a = aw_q.pop_front();
        smem[a] = wd_q.pop_front();
        b_n++; b_drop = 1; b_cnt = 0;
      end
      // R
      if (r_drop) begin bus.rvalid = 0; r_drop = 0; end
      else if (!bus.rvalid && ar_q.size() > 0) begin
        if (r_cnt >= r_dly) begin
          a = ar_q[0];
          bus.rvalid = 1; bus.rid = rid_cfg; bus.rresp = rresp_cfg; bus.rlast = rlast_cfg;
          bus.rdata = smem.exists(a) ? smem[a] : dflt(a);
        end else r_cnt++;
      end
      if (bus.rvalid && bus.rready) begin
        void'(ar_q.pop_front()); r_n++; r_drop = 1; r_cnt = 0;
      end
      // AW
      if (bus.awvalid) begin
        if (aw_cnt > 0 && bus.awaddr !== prev_awaddr) aw_unstable = 1;
        prev_awaddr = bus.awaddr;
        bus.awready = rdy_early || (aw_cnt >= aw_dly);
        aw_cnt++;
      end else begin bus.awready = rdy_early; aw_cnt = 0; end
      if (bus.awvalid && bus.awready) begin
        aw_q.push_back(bus.awaddr); aw_n++; aw_hs_cyc = cyc; aw_hold = aw_cnt; aw_cnt = 0;
        last_awaddr = bus.awaddr; last_awlen = bus.awlen; last_awsize = bus.awsize;
        last_awburst = bus.awburst; last_awid = bus.awid;
      end
      // W
      if (bus.wvalid) begin
        bus.wready = rdy_early || (w_cnt >= w_dly);
        w_cnt++;
      end else begin bus.wready = rdy_early; w_cnt = 0; end
      if (bus.wvalid && bus.wready) begin
        wd_q.push_back(bus.wdata); w_n++; w_hs_cyc = cyc; w_cnt = 0;
        last_wdata = bus.wdata; last_wstrb = bus.wstrb; last_wlast = bus.wlast;
      end
      // AR
      if (bus.arvalid) begin
        if (ar_cnt > 0 && bus.araddr !== prev_araddr) ar_unstable = 1;
        prev_araddr = bus.araddr;
        bus.arready = rdy_early || (ar_cnt >= ar_dly);
        ar_cnt++;
      end else begin bus.arready = rdy_early; ar_cnt = 0; end
      if (bus.arvalid && bus.arready) begin
        ar_q.push_back(bus.araddr); ar_n++; ar_hold = ar_cnt; ar_cnt = 0;
        last_arid = bus.arid;
      end
    end
  end

  // Issues one command and consumes its response after 'hold' stall cycles.
  task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd, output logic er, output int lat);
    int n, acc;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    acc = cyc;
    @(negedge clk);
    cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: no response for addr %h after %0d cycles (required <200)", addr, n);
      rd = 'x; er = 1'bx; lat = -1;
      return;
    end
    lat = cyc - acc; rd = rsp_rdata; er = rsp_err;
    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er || cmd_ready !== 1'b0) hold_bad = 1;
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    ready_after = cmd_ready;
  endtask

  task automatic test_reset();
    reset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    cfg_default(); slv_clear();
    any_valid = 0; aw_unstable = 0; ar_unstable = 0;
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    checks++; if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
      errors++; $display("FAIL reset_bus: got %b want 00000", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}); end
    checks++; if ({rsp_valid, rsp_err} !== 2'b00 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rsp: got v=%b e=%b d=%h want 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
    reset = 0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write_zero_wait();
    logic [31:0] rd; logic er; int lat;
    cfg_default();
    do_cmd(1, 32'h4, 32'hDEADBEEF, 0, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d want 3", lat); end
    checks++; if ({er, rd} !== 33'h0) begin errors++; $display("FAIL wr_rsp: got e=%b d=%h want 0/0", er, rd); end
    checks++; if (last_awaddr !== 32'h4 || last_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_bus: got a=%h d=%h want 4/deadbeef", last_awaddr, last_wdata); end
    checks++; if (last_wstrb !== 4'hF || last_wlast !== 1'b1) begin
      errors++; $display("FAIL wr_strb_last: got %h/%b want f/1", last_wstrb, last_wlast); end
    checks++; if (last_awlen !== 8'd0 || last_awsize !== 3'd2 || last_awburst !== 2'b01 || last_awid !== TID) begin
      errors++; $display("FAIL wr_fields: got len=%0d size=%0d burst=%0d id=%0d want 0/2/1/%0d",
                         last_awlen, last_awsize, last_awburst, last_awid, TID); end
    checks++; if (aw_hs_cyc !== w_hs_cyc) begin errors++; $display("FAIL wr_same_cycle: aw@%0d w@%0d want equal", aw_hs_cyc, w_hs_cyc); end
    checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL wr_ready_after: got %b want 1", ready_after); end
  endtask

  task automatic test_read_delay();
    logic [31:0] rd; logic er; int lat;
    cfg_default(); ar_dly = 5; r_dly = 3; ar_unstable = 0;
    smem[32'h100] = 32'h12345678;
    do_cmd(0, 32'h100, 32'hFFFF_FFFF, 0, rd, er, lat);
    checks++; if (rd !== 32'h12345678 || er !== 1'b0) begin errors++; $display("FAIL rd_data: got %h e=%b want 12345678/0", rd, er); end
    checks++; if (ar_hold !== 6 || ar_unstable) begin errors++; $display("FAIL rd_ar_hold: got %0d unstable=%b want 6/0", ar_hold, ar_unstable); end
    checks++; if (lat !== 11) begin errors++; $display("FAIL rd_latency: got %0d want 11", lat); end
    checks++; if (last_arid !== TID) begin errors++; $display("FAIL rd_arid: got %0d want %0d", last_arid, TID); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] rd; logic er; int lat, a0, w0, b0;
    cfg_default(); aw_dly = 4; aw_unstable = 0;
    a0 = aw_n; w0 = w_n; b0 = b_n;
    do_cmd(1, 32'h1F0, 32'hCAFE_0001, 0, rd, er, lat);
    checks++; if (aw_hs_cyc - w_hs_cyc !== 4) begin errors++; $display("FAIL wa_order: aw-w=%0d want 4", aw_hs_cyc - w_hs_cyc); end
    checks++; if (aw_n - a0 !== 1 || w_n - w0 !== 1 || b_n - b0 !== 1) begin
      errors++; $display("FAIL wa_counts: aw=%0d w=%0d b=%0d want 1/1/1", aw_n - a0, w_n - w0, b_n - b0); end
    checks++; if (aw_hold !== 5 || aw_unstable) begin errors++; $display("FAIL wa_aw_hold: got %0d unstable=%b want 5/0", aw_hold, aw_unstable); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wa_err: got %b want 0", er); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    cfg_default(); bresp_cfg = 2'd2;
    do_cmd(1, 32'h1F4, 32'h1, 0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL bresp_err: got e=%b d=%h want 1/0", er, rd); end
    cfg_default(); rid_cfg = TID + 4'd1;
    do_cmd(0, 32'h1F4, 32'h0, 0, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL rid_err: got %b want 1", er); end
    cfg_default(); rlast_cfg = 1'b0;
    do_cmd(0, 32'h1F4, 32'h0, 0, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL rlast_err: got %b want 1", er); end
    cfg_default(); bid_cfg = TID ^ 4'h8;
    do_cmd(1, 32'h1F8, 32'h2, 0, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL bid_err: got %b want 1", er); end
    cfg_default();
  endtask

  task automatic test_align();
    logic [31:0] rd; logic er; int lat, v0;
    cfg_default(); v0 = any_valid;
    do_cmd(1, 32'h6, 32'h55AA_55AA, 0, rd, er, lat);
    checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL align_wr: got lat=%0d e=%b d=%h want 1/1/0", lat, er, rd); end
    do_cmd(0, 32'h103, 32'h0, 0, rd, er, lat);
    checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL align_rd: got lat=%0d e=%b d=%h want 1/1/0", lat, er, rd); end
    checks++; if (any_valid !== v0) begin errors++; $display("FAIL align_no_traffic: %0d valid cycles want 0", any_valid - v0); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat;
    cfg_default();
    do_cmd(0, 32'h100, 32'h0, 10, rd, er, lat);
    checks++; if (hold_bad) begin errors++; $display("FAIL bp_stable: rsp changed or cmd_ready high during stall, want stable"); end
    checks++; if (rd !== 32'h12345678 || er !== 1'b0) begin errors++; $display("FAIL bp_data: got %h e=%b want 12345678/0", rd, er); end
    checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b want 1", ready_after); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 100; i++) begin
      bit wr, exp_er;
      logic [31:0] a, wd, exp_rd, rd;
      logic er;
      int f, lat;
      wr = 1'($urandom_range(0, 1));
      a = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      wd = $urandom;
      f = $urandom_range(0, 9);
      cfg_default();
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3); rdy_early = 1'($urandom_range(0, 1));
      if (wr && f == 0) bresp_cfg = 2'($urandom_range(1, 3));
      if (wr && f == 1) bid_cfg = TID ^ 4'h1;
      if (!wr && f == 0) rresp_cfg = 2'($urandom_range(1, 3));
      if (!wr && f == 1) rid_cfg = TID + 4'd1;
      if (!wr && f == 2) rlast_cfg = 1'b0;
      if (a[1:0] != 2'b00) begin exp_rd = 0; exp_er = 1; end
      else if (wr) begin ref_mem[a] = wd; exp_rd = 0; exp_er = (f <= 1); end
      else begin exp_rd = ref_mem.exists(a) ? ref_mem[a] : dflt(a); exp_er = (f <= 2); end
      do_cmd(wr, a, wd, $urandom_range(0, 2), rd, er, lat);
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand_data[%0d]: %s %h got %h want %h", i, wr ? "wr" : "rd", a, rd, exp_rd); end
      checks++; if (er !== exp_er) begin errors++; $display("FAIL rand_err[%0d]: %s %h got %b want %b", i, wr ? "wr" : "rd", a, er, exp_er); end
    end
    cfg_default();
  endtask

  task automatic test_async_reset();
    logic [31:0] rd; logic er; int lat, n;
    cfg_default(); aw_dly = 20; w_dly = 20;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h1040; cmd_wdata = 32'h0BAD_F00D;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    checks++; if (bus.awvalid !== 1'b1 || bus.wvalid !== 1'b1) begin
      errors++; $display("FAIL arst_pre: aw=%b w=%b want 1/1", bus.awvalid, bus.wvalid); end
    #2 reset = 1;
    #1;
    checks++; if ({bus.awvalid, bus.wvalid, rsp_valid, cmd_ready} !== 4'b0) begin
      errors++; $display("FAIL arst_drop: aw=%b w=%b rv=%b cr=%b want 0000", bus.awvalid, bus.wvalid, rsp_valid, cmd_ready); end
    @(negedge clk);
    slv_clear(); cfg_default();
    reset = 0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b want 1", cmd_ready); end
    do_cmd(0, 32'h2000, 32'h0, 0, rd, er, lat);
    checks++; if (rd !== dflt(32'h2000) || er !== 1'b0 || lat !== 3) begin
      errors++; $display("FAIL arst_read: got %h e=%b lat=%0d want %h/0/3", rd, er, lat, dflt(32'h2000)); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_delay();
    test_w_before_aw();
    test_errors();
    test_align();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
